// File: rtl/fifo_async_pkg.sv
// rtl/fifo_async_pkg.sv - shared types, defaults and helpers for the async FIFO read side
package fifo_async_pkg;

  localparam int FIFO_DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic {OUT_EMPTY, OUT_FULL} fifo_output_state_t;

  // One extra wrap bit distinguishes full from empty when addresses match.
  function automatic int fifo_pointer_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_stage.sv
// rtl/fifo_fwft_stage.sv - first-word-fall-through output stage state and valid/ready logic
module fifo_fwft_stage
  import fifo_async_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fetch,
  input  logic data_out_ready,
  output logic data_out_valid,
  output logic data_out_valid_next
);

  fifo_output_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= OUT_EMPTY;
    else       state <= state_next;
  end

  // A fetch while full only happens alongside a handshake, so the stage stays full.
  always_comb begin
    state_next = state;
    unique case (state)
      OUT_EMPTY: if (fetch) state_next = OUT_FULL;
      OUT_FULL:  if (data_out_ready && !fetch) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  always_comb begin
    data_out_valid      = (state == OUT_FULL);
    data_out_valid_next = (state_next == OUT_FULL);
  end

endmodule

// File: rtl/fifo_read_controller.sv
// rtl/fifo_read_controller.sv - async FIFO read-side controller; FIFO_READ_ALMOST_EMPTY_EN adds almost_empty
module fifo_read_controller
  import fifo_async_pkg::*;
#(
  parameter int ADDR_WIDTH         = FIFO_DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH         = 8,
  parameter int POINTER_WIDTH      = fifo_pointer_width(ADDR_WIDTH),
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [POINTER_WIDTH-1:0] write_pointer_sync,
  output logic [POINTER_WIDTH-1:0] read_pointer,
  output logic                     mem_read_enable,
  output logic [ADDR_WIDTH-1:0]    mem_read_address,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic                     empty,
  output logic [POINTER_WIDTH-1:0] fill_level,
`ifdef FIFO_READ_ALMOST_EMPTY_EN
  output logic                     almost_empty,
`endif
  output logic                     overflow_error
);

  localparam logic [POINTER_WIDTH-1:0] DEPTH = POINTER_WIDTH'(2 ** ADDR_WIDTH);

  if (POINTER_WIDTH != ADDR_WIDTH + 1 || ALMOST_EMPTY_LEVEL < 0 ||
      ALMOST_EMPTY_LEVEL > 2 ** ADDR_WIDTH + 1) begin : g_param_check
    $error("fifo_read_controller: inconsistent parameters");
  end

  logic                     ram_empty;
  logic                     fetch;
  logic                     data_out_valid_next;
  logic [POINTER_WIDTH-1:0] distance;
  logic [POINTER_WIDTH-1:0] distance_next;
  logic [POINTER_WIDTH-1:0] read_pointer_next;
  logic [POINTER_WIDTH-1:0] fill_level_next;

  // Pointers differing only in the wrap bit mean a full RAM, not an empty one.
  assign ram_empty = (read_pointer == write_pointer_sync);
  assign fetch     = !reset && !ram_empty && (!data_out_valid || data_out_ready);

  assign distance          = write_pointer_sync - read_pointer;
  assign read_pointer_next = read_pointer + POINTER_WIDTH'(fetch);
  assign distance_next     = write_pointer_sync - read_pointer_next;
  assign fill_level_next   = distance_next + POINTER_WIDTH'(data_out_valid_next);

  assign mem_read_enable  = fetch;
  assign mem_read_address = read_pointer[ADDR_WIDTH-1:0];
  assign data_out         = mem_read_data;
  assign empty            = !data_out_valid;

  fifo_fwft_stage u_fwft_stage (
    .clk                 (clk),
    .reset               (reset),
    .fetch               (fetch),
    .data_out_ready      (data_out_ready),
    .data_out_valid      (data_out_valid),
    .data_out_valid_next (data_out_valid_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer   <= '0;
      fill_level     <= '0;
      overflow_error <= 1'b0;
    end else begin
      read_pointer   <= read_pointer_next;
      fill_level     <= fill_level_next;
      overflow_error <= overflow_error || (distance > DEPTH);
    end
  end

`ifdef FIFO_READ_ALMOST_EMPTY_EN
  always_ff @(posedge clk) begin
    if (reset) almost_empty <= 1'b1;
    else       almost_empty <= (fill_level_next <= POINTER_WIDTH'(ALMOST_EMPTY_LEVEL));
  end
`endif

endmodule

// File: tb/tb_fifo_read_controller.sv
// tb/tb_fifo_read_controller.sv - self-checking bench for fifo_read_controller against a word-count model
module tb_fifo_read_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] write_pointer_sync = '0;
  logic [4:0] read_pointer;
  logic       mem_read_enable;
  logic [3:0] mem_read_address;
  logic [7:0] mem_read_data = '0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       empty;
  logic [4:0] fill_level;
  logic       overflow_error;

  always #5 clk = ~clk;

  fifo_read_controller dut (
    .clk                (clk),
    .reset              (reset),
    .write_pointer_sync (write_pointer_sync),
    .read_pointer       (read_pointer),
    .mem_read_enable    (mem_read_enable),
    .mem_read_address   (mem_read_address),
    .mem_read_data      (mem_read_data),
    .data_out           (data_out),
    .data_out_valid     (data_out_valid),
    .data_out_ready     (data_out_ready),
    .empty              (empty),
    .fill_level         (fill_level),
    .overflow_error     (overflow_error)
  );

  // Simple dual-port RAM read port: registered, holds while enable is low.
  logic [7:0] bench_mem [16];
  always @(posedge clk) if (mem_read_enable) mem_read_data <= bench_mem[mem_read_address];

  int         errors = 0;
  int         checks = 0;
  int         written = 0;
  int         consumed = 0;
  int         exp_fill = 0;
  bit         exp_valid = 0;
  bit         model_on = 0;
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    bench_mem[written % 16] = d;
    q.push_back(d);
    written++;
  endtask

  // Model: words held = words written - words consumed; the output stage is occupied iff any are held.
  task automatic cycle(input bit rst, input bit rdy);
    @(negedge clk);
    if (model_on) begin
      chk("fill_level", fill_level, exp_fill);
      chk("data_out_valid", data_out_valid, exp_valid);
      chk("empty", empty, !exp_valid);
      chk("read_pointer", read_pointer, 32'(5'(consumed + exp_valid)));
      chk("mem_read_address", mem_read_address, 32'(4'(consumed + exp_valid)));
      chk("overflow_clear", overflow_error, 0);
    end
    reset              = rst;
    data_out_ready     = rdy;
    write_pointer_sync = rst ? 5'd0 : 5'(written);
    #1;
    if (model_on) begin
      chk("mem_read_enable", mem_read_enable,
          !rst && (written - consumed - int'(exp_valid) > 0) && (!exp_valid || rdy));
      if (exp_valid) chk("data_out", data_out, q[0]);
    end
    if (rst) begin
      written = 0; consumed = 0; q.delete(); exp_fill = 0; exp_valid = 0;
    end else if (model_on) begin
      if (exp_valid && rdy) begin
        void'(q.pop_front());
        consumed++;
      end
      exp_fill  = written - consumed;
      exp_valid = (exp_fill > 0);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  budget;
  int  n;
  int  maxf;
  bit  saw31;
  bit  wrapped;

  initial begin
    cycle(1, 0);
    model_on = 1;
    cycle(1, 0);

    // Idle after reset: nothing fetched, nothing valid.
    for (int i = 0; i < 4; i++) cycle(0, 0);
    #1;
    chk("idle_empty", empty, 1);
    chk("idle_valid", data_out_valid, 0);
    chk("idle_fill", fill_level, 0);
    chk("idle_rp", read_pointer, 0);

    // Four preloaded words stream out on consecutive cycles.
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1);
      #1;
      chk("stream_valid", data_out_valid, 1);
      chk("stream_data", data_out, 32'hA0 + i);
    end
    cycle(0, 1);
    #1;
    chk("stream_end_empty", empty, 1);
    chk("stream_end_rp", read_pointer, 4);

    // Stall with ready low: first word holds, then drains in order.
    cycle(1, 0);
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) cycle(0, 0);
    #1;
    chk("stall_valid", data_out_valid, 1);
    chk("stall_data", data_out, 32'hA0);
    chk("stall_rp", read_pointer, 1);
    chk("stall_fill", fill_level, 4);
    for (int i = 0; i < 6; i++) cycle(0, 1);
    chk("stall_drained", q.size(), 0);

    // Random streaming of 40 words through a wrap of the read pointer.
    cycle(1, 0);
    budget = 0; maxf = 0; saw31 = 0; wrapped = 0;
    while ((written < 40 || q.size() > 0) && budget < 3000) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++)
        if (written < 40 && written - consumed - int'(exp_valid) < 16) push_word(8'($urandom));
      cycle(0, $urandom_range(0, 2) == 0);
      budget++;
      #1;
      if (read_pointer == 5'd31) saw31 = 1;
      if (saw31 && read_pointer == 5'd0) wrapped = 1;
      if (int'(fill_level) > maxf) maxf = int'(fill_level);
    end
    chk("random_completed", budget < 3000, 1);
    chk("random_pointer_wrapped", wrapped, 1);
    chk("random_fill_bound", maxf <= 17, 1);
    chk("random_consumed", consumed, 40);

    // Corrupt pointer distance sets a sticky error.
    cycle(1, 0);
    model_on = 0;
    written = 17;
    cycle(0, 0);
    #1;
    chk("overflow_set", overflow_error, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1);
    #1;
    chk("overflow_sticky", overflow_error, 1);
    cycle(1, 0);
    #1;
    chk("overflow_reset", overflow_error, 0);
    model_on = 1;

    // Reset while a word is presented drops everything.
    cycle(1, 0);
    for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
    cycle(0, 0);
    #1;
    chk("pre_reset_valid", data_out_valid, 1);
    chk("pre_reset_fill", fill_level, 6);
    cycle(1, 0);
    #1;
    chk("post_reset_valid", data_out_valid, 0);
    chk("post_reset_fill", fill_level, 0);
    chk("post_reset_rp", read_pointer, 0);
    chk("post_reset_empty", empty, 1);
    chk("post_reset_mre", mem_read_enable, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
